decrypter_ct_loader: RTL and testbench

Upstream feeder for `decrypter_pl`. It accepts ciphertext and secret-key bytes on a byte-wide valid/ready stream and writes them into the decrypter's input RAM ports (`bwe_c`/`baddr_c`, `bwe_h`/`baddr_h`, `bwe_sk`/`baddr_sk`). It checks frame lengths against `tlast` and raises `ready` once a full ciphertext is staged and a key is present. It releases `ready` on the decrypter's `start_stage` pulse, so the next ciphertext can stream in while the current one is processed.

---
 rtl/newhope_pkg.sv | 23 ++
 rtl/decrypter_ct_loader.sv | 202 ++++++++++++++++++++
 tb/tb_decrypter_ct_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/newhope_pkg.sv
// Shared constants and state encoding for the NewHope decrypter front end.
package newhope_pkg;

  localparam int unsigned C_BYTES   = 896;
  localparam int unsigned H_BYTES   = 192;
  localparam int unsigned SK_BYTES  = 896;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned C_ADDR_W  = 10;
  localparam int unsigned H_ADDR_W  = 8;
  localparam int unsigned SK_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_SK = 3'd1,
    ST_LOAD_C  = 3'd2,
    ST_LOAD_H  = 3'd3,
    ST_FULL    = 3'd4,
    ST_DRAIN   = 3'd5
  } ld_state_e;

endpackage

// File: rtl/decrypter_ct_loader.sv
// Byte-stream loader: stages ciphertext (C then H) and secret key into the
// decrypter input RAMs, checking frame length against tlast.
module decrypter_ct_loader
  import newhope_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tlast,
  input  logic                 s_tuser,
  input  logic                 start_stage,
  output logic                 ready,
  output logic                 sk_valid,
  output logic                 frame_err,
  output logic                 bwe_c,
  output logic [C_ADDR_W-1:0]  baddr_c,
  output logic [DATA_W-1:0]    bdo_c,
  output logic                 bwe_h,
  output logic [H_ADDR_W-1:0]  baddr_h,
  output logic [DATA_W-1:0]    bdo_h,
  output logic                 bwe_sk,
  output logic [SK_ADDR_W-1:0] baddr_sk,
  output logic [DATA_W-1:0]    bdo_sk
);

  ld_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s_tready_q;
  logic                   ready_q;
  logic                   sk_valid_q;
  logic                   frame_err_q;
  logic                   bwe_c_q, bwe_h_q, bwe_sk_q;
  logic [C_ADDR_W-1:0]    baddr_c_q;
  logic [H_ADDR_W-1:0]    baddr_h_q;
  logic [SK_ADDR_W-1:0]   baddr_sk_q;
  logic [DATA_W-1:0]      bdo_c_q, bdo_h_q, bdo_sk_q;

  logic accept_c;
  logic cnt_last_sk_c;
  logic cnt_last_c_c;
  logic cnt_last_h_c;

  assign accept_c      = s_tvalid & s_tready_q;
  assign cnt_last_sk_c = (cnt_q == CNT_W'(SK_BYTES - 1));
  assign cnt_last_c_c  = (cnt_q == CNT_W'(C_BYTES - 1));
  assign cnt_last_h_c  = (cnt_q == CNT_W'(H_BYTES - 1));

  // cnt_q is the index of the next byte within the current target RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      s_tready_q  <= 1'b0;
      ready_q     <= 1'b0;
      sk_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bwe_c_q     <= 1'b0;
      bwe_h_q     <= 1'b0;
      bwe_sk_q    <= 1'b0;
      baddr_c_q   <= '0;
      baddr_h_q   <= '0;
      baddr_sk_q  <= '0;
      bdo_c_q     <= '0;
      bdo_h_q     <= '0;
      bdo_sk_q    <= '0;
    end else begin
      bwe_c_q     <= 1'b0;
      bwe_h_q     <= 1'b0;
      bwe_sk_q    <= 1'b0;
      frame_err_q <= 1'b0;
      s_tready_q  <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (accept_c) begin
            cnt_q <= CNT_W'(1);
            if (s_tuser) begin
              // Key RAM is being overwritten, so the old key is no longer usable.
              bwe_sk_q   <= 1'b1;
              baddr_sk_q <= '0;
              bdo_sk_q   <= s_tdata;
              sk_valid_q <= 1'b0;
              if (s_tlast) begin
                frame_err_q <= 1'b1;
                cnt_q       <= '0;
              end else begin
                state_q <= ST_LOAD_SK;
              end
            end else begin
              bwe_c_q   <= 1'b1;
              baddr_c_q <= '0;
              bdo_c_q   <= s_tdata;
              if (s_tlast) begin
                frame_err_q <= 1'b1;
                cnt_q       <= '0;
              end else begin
                state_q <= ST_LOAD_C;
              end
            end
          end
        end
        ST_LOAD_SK: begin
          if (accept_c) begin
            bwe_sk_q   <= 1'b1;
            baddr_sk_q <= SK_ADDR_W'(cnt_q);
            bdo_sk_q   <= s_tdata;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_last_sk_c) begin
              cnt_q <= '0;
              if (s_tlast) begin
                sk_valid_q <= 1'b1;
                state_q    <= ST_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_DRAIN;
              end
            end else if (s_tlast) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_LOAD_C: begin
          if (accept_c) begin
            bwe_c_q   <= 1'b1;
            baddr_c_q <= C_ADDR_W'(cnt_q);
            bdo_c_q   <= s_tdata;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (s_tlast) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_IDLE;
            end else if (cnt_last_c_c) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD_H;
            end
          end
        end
        ST_LOAD_H: begin
          if (accept_c) begin
            bwe_h_q   <= 1'b1;
            baddr_h_q <= cnt_q[H_ADDR_W-1:0];
            bdo_h_q   <= s_tdata;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (cnt_last_h_c) begin
              cnt_q <= '0;
              if (s_tlast) begin
                state_q    <= ST_FULL;
                s_tready_q <= 1'b0;
                ready_q    <= sk_valid_q;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_DRAIN;
              end
            end else if (s_tlast) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_FULL: begin
          // A start without a valid key is ignored; the stream stays stalled.
          if (start_stage && ready_q) begin
            ready_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            ready_q    <= sk_valid_q;
            s_tready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (accept_c && s_tlast) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign s_tready  = s_tready_q;
  assign ready     = ready_q;
  assign sk_valid  = sk_valid_q;
  assign frame_err = frame_err_q;
  assign bwe_c     = bwe_c_q;
  assign baddr_c   = baddr_c_q;
  assign bdo_c     = bdo_c_q;
  assign bwe_h     = bwe_h_q;
  assign baddr_h   = baddr_h_q;
  assign bdo_h     = bdo_h_q;
  assign bwe_sk    = bwe_sk_q;
  assign baddr_sk  = baddr_sk_q;
  assign bdo_sk    = bdo_sk_q;

endmodule

// File: tb/tb_decrypter_ct_loader.sv
// Directed bench for decrypter_ct_loader: frame loading, error handling, handoff.
module tb_decrypter_ct_loader;

  localparam int NC  = 896;
  localparam int NH  = 192;
  localparam int NSK = 896;
  localparam int NCT = NC + NH;

  logic       clk;
  logic       rst;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tlast;
  logic       s_tuser;
  logic       start_stage;
  logic       ready;
  logic       sk_valid;
  logic       frame_err;
  logic       bwe_c;
  logic [9:0] baddr_c;
  logic [7:0] bdo_c;
  logic       bwe_h;
  logic [7:0] baddr_h;
  logic [7:0] bdo_h;
  logic       bwe_sk;
  logic [9:0] baddr_sk;
  logic [7:0] bdo_sk;

  int n_checks;
  int n_fail;

  // write recorder
  logic [7:0] mem_c  [1024];
  logic [7:0] mem_h  [256];
  logic [7:0] mem_sk [1024];
  int n_wc, n_wh, n_wsk, n_multi, n_err;

  decrypter_ct_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .start_stage(start_stage),
    .ready      (ready),
    .sk_valid   (sk_valid),
    .frame_err  (frame_err),
    .bwe_c      (bwe_c),
    .baddr_c    (baddr_c),
    .bdo_c      (bdo_c),
    .bwe_h      (bwe_h),
    .baddr_h    (baddr_h),
    .bdo_h      (bdo_h),
    .bwe_sk     (bwe_sk),
    .baddr_sk   (baddr_sk),
    .bdo_sk     (bdo_sk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (bwe_c === 1'b1) begin mem_c[baddr_c] = bdo_c; n_wc++; end
    if (bwe_h === 1'b1) begin mem_h[baddr_h] = bdo_h; n_wh++; end
    if (bwe_sk === 1'b1) begin mem_sk[baddr_sk] = bdo_sk; n_wsk++; end
    if ((int'(bwe_c) + int'(bwe_h) + int'(bwe_sk)) > 1) n_multi++;
    if (frame_err === 1'b1) n_err++;
  end

  task automatic clear_mon();
    for (int i = 0; i < 1024; i++) begin mem_c[i] = 'x; mem_sk[i] = 'x; end
    for (int i = 0; i < 256; i++) mem_h[i] = 'x;
    n_wc = 0; n_wh = 0; n_wsk = 0; n_err = 0;
  endtask

  // Drives one frame at one byte per cycle; data byte k = seed + k.
  task automatic send_frame(input logic user, input int n, input int last_at,
                            input logic [7:0] seed, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      int guard;
      guard    = 0;
      s_tvalid = 1'b1;
      s_tdata  = seed + 8'(k);
      s_tlast  = (k == last_at);
      s_tuser  = (k == 0) ? user : 1'b0;
      while (s_tready !== 1'b1 && guard < 64) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 64) begin
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic pulse_start();
    start_stage = 1'b1;
    @(negedge clk);
    start_stage = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_tready, ready, sk_valid, frame_err, bwe_c, bwe_h, bwe_sk} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000000",
               {s_tready, ready, sk_valid, frame_err, bwe_c, bwe_h, bwe_sk});
    end
    n_checks++;
    if ({baddr_c, baddr_h, baddr_sk, bdo_c, bdo_h, bdo_sk} !== 52'h0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got %h want 0",
               {baddr_c, baddr_h, baddr_sk, bdo_c, bdo_h, bdo_sk});
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready_rise: got %b want 1", s_tready);
    end
    n_checks++;
    if ({ready, sk_valid, frame_err, bwe_c, bwe_h, bwe_sk} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_release_flags: got %b want 000000",
               {ready, sk_valid, frame_err, bwe_c, bwe_h, bwe_sk});
    end
  endtask

  task automatic test_ct_without_sk();
    bit ok;
    clear_mon();
    send_frame(1'b0, NCT, NCT - 1, 8'h21, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL nosk_send: timeout got 0 want 1"); end
    n_checks++;
    if ({ready, s_tready} !== 2'b00) begin
      n_fail++;
      $display("FAIL nosk_full: ready,s_tready got %b want 00", {ready, s_tready});
    end
    pulse_start();
    @(negedge clk);
    n_checks++;
    if ({ready, s_tready} !== 2'b00) begin
      n_fail++;
      $display("FAIL nosk_start_ignored: ready,s_tready got %b want 00", {ready, s_tready});
    end
    apply_reset();
  endtask

  task automatic test_sk_load();
    bit ok;
    int bad;
    clear_mon();
    send_frame(1'b1, NSK, NSK - 1, 8'h30, ok);
    @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sk_send: timeout got 0 want 1"); end
    n_checks++;
    if (n_wsk !== NSK || n_wc !== 0 || n_wh !== 0) begin
      n_fail++;
      $display("FAIL sk_write_count: sk/c/h got %0d/%0d/%0d want %0d/0/0", n_wsk, n_wc, n_wh, NSK);
    end
    bad = 0;
    for (int k = 0; k < NSK; k++) if (mem_sk[k] !== 8'(8'h30 + k)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL sk_data: bad bytes got %0d want 0", bad); end
    n_checks++;
    if ({sk_valid, ready, n_err != 0} !== 3'b100) begin
      n_fail++;
      $display("FAIL sk_flags: sk_valid,ready,err got %b want 100", {sk_valid, ready, n_err != 0});
    end
  endtask

  task automatic test_ct_load();
    bit ok;
    int bad;
    clear_mon();
    send_frame(1'b0, NCT, NCT - 1, 8'h55, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ct_send: timeout got 0 want 1"); end
    n_checks++;
    if (bwe_h !== 1'b1 || baddr_h !== 8'd191 || bdo_h !== 8'(8'h55 + NCT - 1)) begin
      n_fail++;
      $display("FAIL ct_last_h_write: we/addr/data got %b/%0d/%h want 1/191/%h",
               bwe_h, baddr_h, bdo_h, 8'(8'h55 + NCT - 1));
    end
    n_checks++;
    if ({ready, s_tready} !== 2'b10) begin
      n_fail++;
      $display("FAIL ct_ready_rise: ready,s_tready got %b want 10", {ready, s_tready});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ready, s_tready} !== 2'b10) begin
      n_fail++;
      $display("FAIL ct_hold_full: ready,s_tready got %b want 10", {ready, s_tready});
    end
    n_checks++;
    if (n_wc !== NC || n_wh !== NH || n_wsk !== 0 || n_multi !== 0) begin
      n_fail++;
      $display("FAIL ct_write_count: c/h/sk/multi got %0d/%0d/%0d/%0d want %0d/%0d/0/0",
               n_wc, n_wh, n_wsk, n_multi, NC, NH);
    end
    bad = 0;
    for (int k = 0; k < NC; k++) if (mem_c[k] !== 8'(8'h55 + k)) bad++;
    for (int j = 0; j < NH; j++) if (mem_h[j] !== 8'(8'h55 + NC + j)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL ct_data: bad bytes got %0d want 0", bad); end
    pulse_start();
    n_checks++;
    if ({ready, s_tready} !== 2'b01) begin
      n_fail++;
      $display("FAIL ct_start_release: ready,s_tready got %b want 01", {ready, s_tready});
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int bad;
    clear_mon();
    send_frame(1'b0, 501, 500, 8'hA0, ok1);
    n_checks++;
    if ({ready, s_tready} !== 2'b01) begin
      n_fail++;
      $display("FAIL early_tlast_idle: ready,s_tready got %b want 01", {ready, s_tready});
    end
    send_frame(1'b0, NCT, NCT - 1, 8'h11, ok2);
    n_checks++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL b2b_send: timeout got 0 want 1"); end
    n_checks++;
    if (n_err !== 1) begin
      n_fail++;
      $display("FAIL early_tlast_err: pulses got %0d want 1", n_err);
    end
    n_checks++;
    if ({ready, s_tready, sk_valid} !== 3'b101) begin
      n_fail++;
      $display("FAIL b2b_ready: ready,s_tready,sk_valid got %b want 101", {ready, s_tready, sk_valid});
    end
    bad = 0;
    for (int k = 0; k < NC; k++) if (mem_c[k] !== 8'(8'h11 + k)) bad++;
    for (int j = 0; j < NH; j++) if (mem_h[j] !== 8'(8'h11 + NC + j)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_data: bad bytes got %0d want 0", bad); end
    pulse_start();
  endtask

  task automatic test_long_frame();
    bit ok;
    int bad;
    clear_mon();
    send_frame(1'b0, NCT + 2, NCT + 1, 8'h42, ok);
    @(negedge clk);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL long_send: timeout got 0 want 1"); end
    n_checks++;
    if (n_err !== 1) begin
      n_fail++;
      $display("FAIL long_err: pulses got %0d want 1", n_err);
    end
    n_checks++;
    if (n_wc !== NC || n_wh !== NH) begin
      n_fail++;
      $display("FAIL long_drain_writes: c/h got %0d/%0d want %0d/%0d", n_wc, n_wh, NC, NH);
    end
    n_checks++;
    if ({ready, s_tready} !== 2'b01) begin
      n_fail++;
      $display("FAIL long_after_drain: ready,s_tready got %b want 01", {ready, s_tready});
    end
    send_frame(1'b0, NCT, NCT - 1, 8'h77, ok);
    n_checks++;
    if (!ok || ready !== 1'b1 || n_err !== 1 || n_wh !== 2 * NH) begin
      n_fail++;
      $display("FAIL long_next_frame: ok/ready/err/hw got %b/%b/%0d/%0d want 1/1/1/%0d",
               ok, ready, n_err, n_wh, 2 * NH);
    end
    bad = 0;
    for (int j = 0; j < NH; j++) if (mem_h[j] !== 8'(8'h77 + NC + j)) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL long_next_data: bad bytes got %0d want 0", bad); end
    pulse_start();
    n_checks++;
    if (n_multi !== 0) begin
      n_fail++;
      $display("FAIL single_bwe: multi-write cycles got %0d want 0", n_multi);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_multi     = 0;
    rst         = 1'b0;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_tuser     = 1'b0;
    start_stage = 1'b0;
    clear_mon();
    @(negedge clk);
    test_reset();
    test_ct_without_sk();
    test_sk_load();
    test_ct_load();
    test_back_to_back();
    test_long_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
